sha1_step_seq: RTL and testbench
================================

SHA1_STEP_SEQ -- requirements
Module: sha1_step_seq

Interface
REQ-001 SHALL have parameter STEPS, default 5: number of RUN steps per operation, legal range 1..255.
REQ-002 SHALL have parameter ADDR_STRIDE, default 4: byte increment applied to the address output per advancing step.
REQ-003 SHALL have parameter CNT_W, default 8: width of the step counter; STEPS SHALL be <= 2^CNT_W - 1.
REQ-004 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start_i, input, 1: operation request, sampled each cycle.
REQ-007 SHALL have port abort_i, input, 1: cancel the current operation.
REQ-008 SHALL have port ready_i, input, 1: downstream ready to accept a step; used only when SHA1_STEP_SEQ_STALL_EN is defined.
REQ-009 SHALL have port sha1_para_i, input, 32: parameter word latched on accepted start.
REQ-010 SHALL have port sha1_addr_i, input, 32: base address latched on accepted start.
REQ-011 SHALL have port busy_o, output, 1: high while in RUN.
REQ-012 SHALL have port done_o, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port err_o, output, 1: one-cycle pulse on a start rejected in RUN.
REQ-014 SHALL have port step_o, output, CNT_W: current step index.
REQ-015 SHALL have port sha1_para_o, output, 32: latched parameter word.
REQ-016 SHALL have port sha1_addr_o, output, 32: current step address.

Function
REQ-017 SHALL implement three states, IDLE, RUN and DONE; busy_o=1 only in RUN, and done_o=1 only in DONE.
REQ-018 SHALL accept start_i in IDLE or DONE: the next cycle is in RUN, with step_o=0, sha1_para_o=sha1_para_i and sha1_addr_o=sha1_addr_i.
REQ-019 SHALL advance in RUN on each advance cycle (every RUN cycle, or RUN with ready_i=1 under stall mode): step_o+1 and sha1_addr_o+ADDR_STRIDE.
REQ-020 SHALL go from RUN to DONE when advancing with step_o==STEPS-1; step_o and sha1_addr_o hold their final values in DONE.
REQ-021 SHALL go from DONE to IDLE after exactly one cycle unless start_i=1, in which case it goes to RUN (back-to-back); done_o is therefore never longer than 1 cycle.
REQ-022 SHALL ignore start_i in RUN, leave state and outputs unchanged, and pulse err_o for the following cycle.
REQ-023 SHALL, on abort_i=1 in RUN, go to IDLE next cycle with step_o=0; no done_o is produced, and abort has priority over advance and over a concurrent start.
REQ-024 SHALL ignore abort_i in IDLE and DONE; start_i with abort_i in IDLE SHALL be accepted.
REQ-025 SHALL compute sha1_addr_o modulo 2^32, wrapping silently with no flag.
REQ-026 SHALL, with STEPS=1, spend exactly one RUN cycle (no stall) before DONE.
REQ-027 SHALL give an unstalled operation a latency of start cycle + STEPS RUN cycles, with done_o in cycle STEPS+1 after start.
REQ-028 SHALL return sha1_para_o, sha1_addr_o and step_o to 0 in IDLE only on reset or abort; normal DONE to IDLE holds the last values.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, go to IDLE with busy_o=0, done_o=0, err_o=0, step_o=0, sha1_para_o=0 and sha1_addr_o=0.
REQ-030 SHALL discard an in-flight operation on reset asserted in RUN or DONE, with no done_o afterwards; rst overrides start_i and abort_i.

Configuration
REQ-031 SHALL, with SHA1_STEP_SEQ_STALL_EN defined, advance in RUN only when ready_i=1; RUN cycles with ready_i=0 hold step_o and sha1_addr_o, and abort_i remains effective during a stall.
REQ-032 SHALL, without SHA1_STEP_SEQ_STALL_EN, ignore ready_i and advance on every RUN cycle.

Verification
REQ-033 SHALL cover: defaults, start with para=0xDEADBEEF, addr=0x1000 -> busy 5 cycles, addr 0x1000..0x1010, done_o one pulse in cycle 6, sha1_para_o=0xDEADBEEF.
REQ-034 SHALL cover: start again at step 2 of a run -> err_o one pulse, step sequence 0..4 undisturbed, single done_o.
REQ-035 SHALL cover: abort_i at step 3 -> IDLE next cycle, step_o=0, no done_o; then a new start runs to completion normally.
REQ-036 SHALL cover: addr=0xFFFFFFF8, STRIDE 4, STEPS 5 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, 0x8.
REQ-037 SHALL cover: stall build with ready_i low for 3 cycles at step 1 -> step_o and addr held, done after 8 RUN cycles; non-stall build ignores ready_i.
REQ-038 SHALL cover: rst at step 2, then start during DONE (back-to-back) -> reset yields all-zero outputs and no done_o; back-to-back start yields a second full run with 2 done pulses total.

Source files
------------

// File: rtl/sha1_step_seq.sv
// Step sequencer: on start, walks STEPS address steps from a latched base, then pulses done_o.
// Define SHA1_STEP_SEQ_STALL_EN to gate each RUN advance on ready_i.
module sha1_step_seq #(
  parameter int STEPS       = 5,
  parameter int ADDR_STRIDE = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             ready_i,
  input  logic [31:0]      sha1_para_i,
  input  logic [31:0]      sha1_addr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] step_o,
  output logic [31:0]      sha1_para_o,
  output logic [31:0]      sha1_addr_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
  localparam logic [31:0]      STRIDE    = 32'(ADDR_STRIDE);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_step, w_step_next;
  logic [31:0]      r_para, w_para_next;
  logic [31:0]      r_addr, w_addr_next;
  logic             r_err, w_err_next;
  logic             w_advance;

`ifdef SHA1_STEP_SEQ_STALL_EN
  assign w_advance = (r_state == RUN) && ready_i;
`else
  // ready_i is deliberately a don't-care here; the OR keeps it connected.
  assign w_advance = (r_state == RUN) && (ready_i || 1'b1);
`endif

  always_comb begin
    w_state_next = r_state;
    w_step_next  = r_step;
    w_para_next  = r_para;
    w_addr_next  = r_addr;
    w_err_next   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start_i) begin
          w_state_next = RUN;
          w_step_next  = '0;
          w_para_next  = sha1_para_i;
          w_addr_next  = sha1_addr_i;
        end else if (r_state == DONE) begin
          w_state_next = IDLE;
        end
      end
      RUN: begin
        if (abort_i) begin
          w_state_next = IDLE;
          w_step_next  = '0;
          w_para_next  = '0;
          w_addr_next  = '0;
        end else begin
          w_err_next = start_i;
          if (w_advance) begin
            w_step_next = r_step + CNT_W'(1);
            w_addr_next = r_addr + STRIDE;
            if (r_step == LAST_STEP) begin
              w_state_next = DONE;
            end
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_para  <= '0;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_step  <= w_step_next;
      r_para  <= w_para_next;
      r_addr  <= w_addr_next;
      r_err   <= w_err_next;
    end
  end

  assign busy_o      = (r_state == RUN);
  assign done_o      = (r_state == DONE);
  assign err_o       = r_err;
  assign step_o      = r_step;
  assign sha1_para_o = r_para;
  assign sha1_addr_o = r_addr;

endmodule

// File: tb/tb_sha1_step_seq.sv
// Bench for sha1_step_seq: directed scenarios plus random traffic against an operation-level model.
module tb_sha1_step_seq;

  localparam int STEPS  = 5;
  localparam int STRIDE = 4;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst, start_i, abort_i, ready_i;
  logic [31:0]      sha1_para_i, sha1_addr_i;
  logic             busy_o, done_o, err_o;
  logic [CNT_W-1:0] step_o;
  logic [31:0]      sha1_para_o, sha1_addr_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_err    = 0;
  int n_busy   = 0;

  // Model: an operation is (phase, steps taken k, base address, parameter word);
  // the address is always base + k*STRIDE modulo 2^32.
  int          m_phase;  // 0 idle, 1 run, 2 done
  int          m_k;
  logic [31:0] m_base, m_para;
  bit          m_err;

  always #5 clk = ~clk;

  sha1_step_seq #(.STEPS(STEPS), .ADDR_STRIDE(STRIDE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .ready_i(ready_i),
    .sha1_para_i(sha1_para_i), .sha1_addr_i(sha1_addr_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .step_o(step_o),
    .sha1_para_o(sha1_para_o), .sha1_addr_o(sha1_addr_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit adv_allowed();
`ifdef SHA1_STEP_SEQ_STALL_EN
    return ready_i;
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model_update();
    if (rst) begin
      m_phase = 0; m_k = 0; m_base = 0; m_para = 0; m_err = 0;
    end else if (m_phase == 1) begin
      m_err = 0;
      if (abort_i) begin
        m_phase = 0; m_k = 0; m_base = 0; m_para = 0;
      end else begin
        m_err = start_i;
        if (adv_allowed()) begin
          m_k++;
          if (m_k == STEPS) m_phase = 2;
        end
      end
    end else begin
      m_err = 0;
      if (start_i) begin
        m_phase = 1; m_k = 0; m_base = sha1_addr_i; m_para = sha1_para_i;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    if (done_o === 1'b1) n_done++;
    if (err_o === 1'b1) n_err++;
    if (busy_o === 1'b1) n_busy++;
    check_eq("busy", 32'(busy_o), 32'(m_phase == 1));
    check_eq("done", 32'(done_o), 32'(m_phase == 2));
    check_eq("err", 32'(err_o), 32'(m_err));
    check_eq("step", 32'(step_o), 32'(m_k));
    check_eq("para", sha1_para_o, m_para);
    check_eq("addr", sha1_addr_o, m_base + 32'(m_k) * 32'(STRIDE));
  endtask

  task automatic go(input logic s, input logic a, input logic r, input logic rs);
    start_i = s; abort_i = a; ready_i = r; rst = rs;
    tick();
    start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b1; rst = 1'b0;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) go(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  int d0, e0, b0;

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b1;
    sha1_para_i = 32'h0; sha1_addr_i = 32'h0;
    m_phase = 0; m_k = 0; m_base = 0; m_para = 0; m_err = 0;

    // Reset with start and abort asserted: reset wins
    go(1'b1, 1'b1, 1'b1, 1'b1);
    go(1'b0, 1'b0, 1'b1, 1'b1);
    $display("reset: step=%0d addr=0x%08h", step_o, sha1_addr_o);

    // Basic run
    sha1_para_i = 32'hDEADBEEF; sha1_addr_i = 32'h0000_1000;
    d0 = n_done; b0 = n_busy;
    go(1'b1, 1'b0, 1'b1, 1'b0);
    idle_n(7);
    check_eq("basic_done_pulses", 32'(n_done - d0), 32'd1);
    check_eq("basic_busy_cycles", 32'(n_busy - b0), 32'(STEPS));
    $display("basic run: para=0x%08h done pulses=%0d", sha1_para_o, n_done - d0);

    // Start during RUN at step 2
    sha1_para_i = 32'h1234_5678; sha1_addr_i = 32'h0000_2000;
    d0 = n_done; e0 = n_err;
    go(1'b1, 1'b0, 1'b1, 1'b0);
    idle_n(2);
    sha1_para_i = 32'hAAAA_5555; sha1_addr_i = 32'h0000_9000;
    go(1'b1, 1'b0, 1'b1, 1'b0);
    idle_n(5);
    check_eq("restart_err_pulses", 32'(n_err - e0), 32'd1);
    check_eq("restart_done_pulses", 32'(n_done - d0), 32'd1);
    $display("start in RUN: err pulses=%0d", n_err - e0);

    // Abort at step 3 (with a concurrent start), then a clean run
    sha1_para_i = 32'h0BAD_F00D; sha1_addr_i = 32'h0000_3000;
    d0 = n_done;
    go(1'b1, 1'b0, 1'b1, 1'b0);
    idle_n(3);
    go(1'b1, 1'b1, 1'b1, 1'b0);
    idle_n(3);
    check_eq("abort_no_done", 32'(n_done - d0), 32'd0);
    go(1'b1, 1'b1, 1'b1, 1'b0);
    idle_n(7);
    check_eq("after_abort_done", 32'(n_done - d0), 32'd1);
    $display("abort: done pulses after rerun=%0d", n_done - d0);

    // Address wrap
    sha1_addr_i = 32'hFFFF_FFF8;
    go(1'b1, 1'b0, 1'b1, 1'b0);
    idle_n(7);
    $display("wrap: final addr=0x%08h", sha1_addr_o);

    // Stall with ready low at step 1
    sha1_addr_i = 32'h0000_4000;
    b0 = n_busy; d0 = n_done;
    go(1'b1, 1'b0, 1'b1, 1'b0);
    go(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) go(1'b0, 1'b0, 1'b0, 1'b0);
    idle_n(8);
`ifdef SHA1_STEP_SEQ_STALL_EN
    check_eq("stall_busy_cycles", 32'(n_busy - b0), 32'(STEPS + 3));
`else
    check_eq("stall_busy_cycles", 32'(n_busy - b0), 32'(STEPS));
`endif
    check_eq("stall_done_pulses", 32'(n_done - d0), 32'd1);
    $display("ready-low run: busy cycles=%0d", n_busy - b0);

    // Reset mid-run, then back-to-back starts
    d0 = n_done;
    go(1'b1, 1'b0, 1'b1, 1'b0);
    idle_n(2);
    go(1'b0, 1'b0, 1'b1, 1'b1);
    idle_n(3);
    check_eq("reset_no_done", 32'(n_done - d0), 32'd0);
    sha1_addr_i = 32'h0000_5000;
    go(1'b1, 1'b0, 1'b1, 1'b0);
    idle_n(STEPS);
    sha1_addr_i = 32'h0000_6000;
    go(1'b1, 1'b0, 1'b1, 1'b0);
    idle_n(7);
    check_eq("b2b_done_pulses", 32'(n_done - d0), 32'd2);
    $display("back-to-back: done pulses=%0d", n_done - d0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      sha1_para_i = $urandom;
      sha1_addr_i = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      go(1'($urandom_range(7) == 0), 1'($urandom_range(23) == 0),
         1'($urandom_range(3) != 0), 1'($urandom_range(149) == 0));
    end
    $display("random: %0d done pulses, %0d err pulses total", n_done, n_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
